// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit - RV32I instruction-fetch front end.
//
// Owns the PC. Issues word reads to instruction memory (req/ready) and holds
// each fetched word for the decoder (valid/ready). On every accepted
// instruction the decoder's flow signals choose what happens next: halt
// (pc_load=0), redirect, or sequential pc+4.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   mem_req, mem_addr        read request / word-aligned address (pc)
//   mem_ready, mem_rdata     memory response, valid only while mem_req=1
//   inst_valid, inst,        fetched word and its address; inst=NOP_WORD
//   inst_pc                  whenever inst_valid=0
//   inst_ready               decoder accepts inst this cycle
//   pc_load, redirect,       decoder flow control, sampled on accept only
//   redirect_pc
//   resume                   one-cycle pulse to leave HALT
//   halted                   fetch stopped on EBREAK
//   retired_count            (FETCH_PERF_CNT_EN only) accepted-instruction count
//
// Optional feature: define FETCH_PERF_CNT_EN to add retired_count and the
// internal stall_count register.
//
// state | meaning
// IDLE  | just out of reset, no request yet
// FETCH | mem_req=1 at pc, waiting for mem_ready
// HOLD  | instruction presented, waiting for decoder accept
// HALT  | stopped after EBREAK, waiting for resume

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        pc_load,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        resume,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] retired_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] inst_q, inst_nxt;
  logic [31:0] inst_pc_q, inst_pc_nxt;
  logic        accept;

  assign accept = (state == HOLD) && inst_ready;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    inst_nxt    = inst_q;
    inst_pc_nxt = inst_pc_q;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (mem_ready) begin
          inst_nxt    = mem_rdata;
          inst_pc_nxt = pc;
          state_nxt   = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          inst_nxt = NOP_WORD;
          // Halt takes priority over redirect; pc keeps the EBREAK address.
          if (!pc_load) begin
            state_nxt = HALT;
          end else if (redirect) begin
            pc_nxt    = redirect_pc & 32'hFFFF_FFFC;
            state_nxt = FETCH;
          end else begin
            pc_nxt    = pc + 32'd4;
            state_nxt = FETCH;
          end
        end
      end
      HALT: begin
        if (resume) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst_q    <= NOP_WORD;
      inst_pc_q <= RESET_PC;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      inst_q    <= inst_nxt;
      inst_pc_q <= inst_pc_nxt;
    end
  end

  // Outputs come only from state and registers; no input reaches an output.
  assign mem_req    = (state == FETCH);
  assign mem_addr   = pc;
  assign inst_valid = (state == HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign halted     = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_count;

  // Neither counter can move in HALT since both conditions need FETCH/HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_count <= 32'd0;
      stall_count   <= 32'd0;
    end else begin
      if (accept)
        retired_count <= retired_count + 32'd1;
      if (((state == FETCH) && !mem_ready) || ((state == HOLD) && !inst_ready))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
